square_lockin_demod: RTL

- Digital lock-in demodulator directly downstream of the 1f/2f square reference generator in the TDLAS chain.
- Multiplies each ADC sample by a ±1 reference taken from square_1x/square_2x.
- Integrates over a programmable number of samples, then dumps 1f and 2f harmonic results with a one-cycle valid strobe.
- Output feeds the PS-side result FIFO/AXI register bank.

---
 rtl/lockin_pkg.sv | 32 +++
 rtl/lockin_acc_channel.sv | 56 +++++
 rtl/square_lockin_demod.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/lockin_pkg.sv
// lockin_pkg
// Shared definitions for the square-reference lock-in demodulator.
//   state_t      : demodulator FSM states (idle / accumulating)
//   DEF_*        : default sample, counter and accumulator widths
//   MAX_W        : widest accumulator the sign helper supports
//   signed_term  : applies a +1/-1 reference to a sign-extended sample
// No configuration macros are used in this file.
package lockin_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_CNT_W  = 24;
  localparam int DEF_ACC_W  = 48;

  // The sign helper works at a fixed wide width.
  // Channels narrow its result back to their own ACC_W (ACC_W <= MAX_W).
  localparam int MAX_W = 64;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_t;

  // The operand must already be sign-extended to MAX_W.
  // Negating at full width means the most negative sample negates exactly.
  function automatic logic signed [MAX_W-1:0] signed_term(
    input logic signed [MAX_W-1:0] s,
    input logic                    pos
  );
    return pos ? s : -s;
  endfunction

endpackage

// File: rtl/lockin_acc_channel.sv
// lockin_acc_channel
// One signed integrate-and-dump channel of the lock-in demodulator.
// Ports:
//   clk_in    : system clock
//   rst       : asynchronous reset, active-high
//   i_clear   : synchronous clear of the running sum (idle or aborted window)
//   i_accept  : a sample is taken this cycle
//   i_dump    : the accepted sample is the last one of the window
//   i_pos     : reference level, 1 -> +sample, 0 -> -sample
//   i_sample  : signed ADC sample
//   o_result  : signed window result, held until the next dump
// No configuration macros are used in this file.
module lockin_acc_channel
  import lockin_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic                     clk_in,
  input  logic                     rst,
  input  logic                     i_clear,
  input  logic                     i_accept,
  input  logic                     i_dump,
  input  logic                     i_pos,
  input  logic signed [DATA_W-1:0] i_sample,
  output logic signed [ACC_W-1:0]  o_result
);

  logic signed [ACC_W-1:0] r_acc;
  logic signed [MAX_W-1:0] w_ext;
  logic signed [ACC_W-1:0] w_term;
  logic signed [ACC_W-1:0] w_sum;

  assign w_ext  = {{(MAX_W-DATA_W){i_sample[DATA_W-1]}}, i_sample};
  assign w_term = ACC_W'(signed_term(w_ext, i_pos));
  assign w_sum  = r_acc + w_term;

  // The last sample of a window goes straight into the result register.
  // The running sum restarts at zero, so the next window begins on the following sample.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_acc    <= '0;
      o_result <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (i_accept) begin
      if (i_dump) begin
        o_result <= w_sum;
        r_acc    <= '0;
      end else begin
        r_acc <= w_sum;
      end
    end
  end

endmodule

// File: rtl/square_lockin_demod.sv
// square_lockin_demod
// Lock-in demodulator fed by the 1f/2f square reference generator.
// Each accepted ADC sample is multiplied by the +/-1 references.
// The products are integrated over len_q samples.
// The 1f/2f sums are then dumped with a one-cycle result_valid strobe.
// Ports:
//   clk_in       : system clock
//   rst          : asynchronous reset, active-high
//   out_en       : demodulation enable (leaving it low aborts the window)
//   adc_data     : signed sample, qualified by adc_valid
//   adc_valid    : one-cycle sample qualifier
//   ref_1x       : 1f reference (1 -> +1, 0 -> -1)
//   ref_2x       : 2f reference (1 -> +1, 0 -> -1)
//   int_len      : samples per window (0 behaves as 1), latched per window
//   x1_data      : 1f window result
//   x2_data      : 2f window result
//   result_valid : strobe marking a fresh x1_data/x2_data
//   busy         : high while accumulating
//   dc_data      : plain sample sum per window (only with LOCKIN_DC_EN)
// Macro LOCKIN_DC_EN adds the DC channel and the dc_data port.
// ACC_W must be at least DATA_W+CNT_W+1 and at most 64.
module square_lockin_demod
  import lockin_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic                     clk_in,
  input  logic                     rst,
  input  logic                     out_en,
  input  logic signed [DATA_W-1:0] adc_data,
  input  logic                     adc_valid,
  input  logic                     ref_1x,
  input  logic                     ref_2x,
  input  logic [CNT_W-1:0]         int_len,
  output logic signed [ACC_W-1:0]  x1_data,
  output logic signed [ACC_W-1:0]  x2_data,
  output logic                     result_valid,
  output logic                     busy
`ifdef LOCKIN_DC_EN
  ,
  output logic signed [ACC_W-1:0]  dc_data
`endif
);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_lenQ;

  logic [CNT_W-1:0] w_lenMapped;
  logic             w_accept;
  logic             w_abort;
  logic             w_clear;
  logic             w_windowEnd;

  assign w_lenMapped = (int_len == '0) ? CNT_W'(1) : int_len;

  // Dropping out_en wins over everything, including a window-end sample.
  // The partial sums are simply cleared.
  assign w_accept    = (r_state == ST_ACC) && out_en && adc_valid;
  assign w_abort     = (r_state == ST_ACC) && !out_en;
  assign w_clear     = (r_state == ST_IDLE) || w_abort;
  assign w_windowEnd = w_accept && (r_cnt == r_lenQ - CNT_W'(1));

  assign busy = (r_state == ST_ACC);

  // The window length is latched when accumulation starts.
  // It is re-latched at every window end, so a new int_len takes effect only on a window boundary.
  // Back-to-back windows run without a dead cycle.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_lenQ       <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (out_en) begin
            r_state <= ST_ACC;
            r_lenQ  <= w_lenMapped;
          end
        end
        ST_ACC: begin
          if (!out_en) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else if (w_windowEnd) begin
            r_cnt        <= '0;
            r_lenQ       <= w_lenMapped;
            result_valid <= 1'b1;
          end else if (w_accept) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  lockin_acc_channel #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_ch1 (
    .clk_in   (clk_in),
    .rst      (rst),
    .i_clear  (w_clear),
    .i_accept (w_accept),
    .i_dump   (w_windowEnd),
    .i_pos    (ref_1x),
    .i_sample (adc_data),
    .o_result (x1_data)
  );

  lockin_acc_channel #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_ch2 (
    .clk_in   (clk_in),
    .rst      (rst),
    .i_clear  (w_clear),
    .i_accept (w_accept),
    .i_dump   (w_windowEnd),
    .i_pos    (ref_2x),
    .i_sample (adc_data),
    .o_result (x2_data)
  );

`ifdef LOCKIN_DC_EN
  // The DC channel is the same integrator with its reference tied to +1.
  lockin_acc_channel #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_chDc (
    .clk_in   (clk_in),
    .rst      (rst),
    .i_clear  (w_clear),
    .i_accept (w_accept),
    .i_dump   (w_windowEnd),
    .i_pos    (1'b1),
    .i_sample (adc_data),
    .o_result (dc_data)
  );
`endif

endmodule
